// File: rtl/serial_inv_vartheta.sv
// serial_inv_vartheta: column-serial SWAN vartheta layer on one half-state.
// Each of the four columns is rotated in place, one column per cycle, so
// a single column-wide rotator serves the whole block.
// Optional build macro: SWAN_VARTHETA_DIR_EN adds a 'dir' input that selects
// forward (dir=1, rotate right) or inverse (dir=0, rotate left) operation.
// Without the macro only the inverse is built; timing is the same in both.
module serial_inv_vartheta #(
  parameter int unsigned BLOCK_SIZE  = 256,
  parameter int unsigned SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int unsigned COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int unsigned PA          = 1,
  parameter int unsigned PB          = 9,
  parameter int unsigned PC          = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x,
`ifdef SWAN_VARTHETA_DIR_EN
  input  logic                 dir,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state_q;
  logic [1:0]             col_q;
  logic [0:SIDE_SIZE-1]   data_q;
  logic [0:SIDE_SIZE-1]   data_rot;
  logic [0:COLUMN_SIZE-1] col_cur;
  logic [0:COLUMN_SIZE-1] col_new;
  int unsigned            amt;
`ifdef SWAN_VARTHETA_DIR_EN
  logic                   dir_q;
`endif

  // Bit 0 is the MSB, so a left shift of the doubled column moves bits
  // toward index 0; the leading half is then the left rotation.
  function automatic logic [0:COLUMN_SIZE-1] rot_left(
    input logic [0:COLUMN_SIZE-1] c,
    input int unsigned            p
  );
    logic [0:2*COLUMN_SIZE-1] d;
    d = {c, c} << p;
    return d[0:COLUMN_SIZE-1];
  endfunction

`ifdef SWAN_VARTHETA_DIR_EN
  // Right rotation: shift the doubled column toward higher indices and keep
  // the trailing half.
  function automatic logic [0:COLUMN_SIZE-1] rot_right(
    input logic [0:COLUMN_SIZE-1] c,
    input int unsigned            p
  );
    logic [0:2*COLUMN_SIZE-1] d;
    d = {c, c} >> p;
    return d[COLUMN_SIZE:2*COLUMN_SIZE-1];
  endfunction
`endif

  // Select the current column and its rotation amount (column 3 is fixed).
  always_comb begin
    col_cur = '0;
    amt     = 0;
    case (col_q)
      2'd0: begin
        col_cur = data_q[0:COLUMN_SIZE-1];
        amt     = PC;
      end
      2'd1: begin
        col_cur = data_q[COLUMN_SIZE:2*COLUMN_SIZE-1];
        amt     = PB;
      end
      2'd2: begin
        col_cur = data_q[2*COLUMN_SIZE:3*COLUMN_SIZE-1];
        amt     = PA;
      end
      default: begin
        col_cur = data_q[3*COLUMN_SIZE:4*COLUMN_SIZE-1];
        amt     = 0;
      end
    endcase
  end

  // Rotate the selected column in the configured direction.
  always_comb begin
`ifdef SWAN_VARTHETA_DIR_EN
    col_new = dir_q ? rot_right(col_cur, amt) : rot_left(col_cur, amt);
`else
    col_new = rot_left(col_cur, amt);
`endif
  end

  // Write the rotated column back into its slot of the data word.
  always_comb begin
    data_rot = data_q;
    case (col_q)
      2'd0:    data_rot[0:COLUMN_SIZE-1]                 = col_new;
      2'd1:    data_rot[COLUMN_SIZE:2*COLUMN_SIZE-1]     = col_new;
      2'd2:    data_rot[2*COLUMN_SIZE:3*COLUMN_SIZE-1]   = col_new;
      default: data_rot[3*COLUMN_SIZE:4*COLUMN_SIZE-1]   = col_new;
    endcase
  end

  // Control FSM and data register: accept, four rotate cycles, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= '0;
`ifdef SWAN_VARTHETA_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= x;
            col_q   <= 2'd0;
            state_q <= ROT;
`ifdef SWAN_VARTHETA_DIR_EN
            dir_q   <= dir;
`endif
          end
        end
        ROT: begin
          data_q <= data_rot;
          col_q  <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign y         = data_q;

endmodule

// File: tb/tb_serial_inv_vartheta.sv
// Testbench for serial_inv_vartheta: directed vector table, backpressure,
// mid-operation reset, back-to-back streaming and (with
// SWAN_VARTHETA_DIR_EN) a forward/inverse round trip.
module tb_serial_inv_vartheta;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] x;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] y;
`ifdef SWAN_VARTHETA_DIR_EN
  logic         dir_i;
`endif

  int checks = 0;
  int passed = 0;

  serial_inv_vartheta #(
    .BLOCK_SIZE(256),
    .PA(1),
    .PB(9),
    .PC(19)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
`ifdef SWAN_VARTHETA_DIR_EN
    .dir      (dir_i),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [127:0] xin;
    logic [127:0] yexp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // 32-bit word rotations on conventional [31:0] words.
  function automatic logic [31:0] rl32(input logic [31:0] w, input int p);
    return (p == 0) ? w : ((w << p) | (w >> (32 - p)));
  endfunction

  function automatic logic [31:0] rr32(input logic [31:0] w, input int p);
    return (p == 0) ? w : ((w >> p) | (w << (32 - p)));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] v, input bit fwd);
    logic [31:0] w0, w1, w2, w3;
    w0 = v[127:96]; w1 = v[95:64]; w2 = v[63:32]; w3 = v[31:0];
    if (fwd) return {rr32(w0, 19), rr32(w1, 9), rr32(w2, 1), w3};
    return {rl32(w0, 19), rl32(w1, 9), rl32(w2, 1), w3};
  endfunction

  // One transaction with out_ready high; lat counts negedges from the
  // accept edge until out_valid is seen (bounded).
  task automatic do_op(input logic [127:0] xv, input bit d,
                       output logic [127:0] yv, output int lat);
    @(negedge clk);
    x = xv; in_valid = 1'b1; out_ready = 1'b1;
`ifdef SWAN_VARTHETA_DIR_EN
    dir_i = d;
`else
    if (d) x = xv;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    x = ~xv;
`ifdef SWAN_VARTHETA_DIR_EN
    dir_i = ~d;
`endif
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    yv = y;
    @(negedge clk);
  endtask

  logic [127:0] yv, yv2, xr, vexp;
  logic [127:0] q[$];
  int lat, seen;

  initial begin
    tbl[0] = '{128'h00000001_00000001_80000000_12345678, 128'h00080000_00000200_00000001_12345678};
    tbl[1] = '{{128{1'b1}}, {128{1'b1}}};
    tbl[2] = '{128'h0, 128'h0};
    tbl[3] = '{128'h80000000_80000000_00000001_FFFFFFFF, 128'h00040000_00000100_00000002_FFFFFFFF};
    tbl[4] = '{128'h0000FFFF_0000FFFF_0000FFFF_DEADBEEF, 128'hFFF80007_01FFFE00_0001FFFE_DEADBEEF};
    tbl[5] = '{128'hF0000000_F0000000_F0000000_00000000, 128'h00078000_000001E0_E0000001_00000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0;
`ifdef SWAN_VARTHETA_DIR_EN
    dir_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset y", y, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].xin, 1'b0, yv, lat);
      chk($sformatf("vec%0d y", i), yv, tbl[i].yexp);
      chk($sformatf("vec%0d latency", i), lat, 5);
      chk($sformatf("vec%0d out_valid drop", i), out_valid, 0);
      chk($sformatf("vec%0d in_ready back", i), in_ready, 1);
    end

    // Backpressure: hold out_ready low for 3 cycles in DONE
    @(negedge clk);
    x = tbl[0].xin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp rot in_ready", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", lat, 5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", i), out_valid, 1);
      chk($sformatf("bp%0d y", i), y, tbl[0].yexp);
      chk($sformatf("bp%0d in_ready", i), in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    chk("bp ignored input", y, tbl[0].yexp);

    // Reset during the second ROT cycle
    @(negedge clk);
    x = tbl[4].xin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort in_ready", in_ready, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort y", y, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no output", seen, 0);
    chk("abort idle in_ready", in_ready, 1);

    // Back-to-back streaming: one accept every 6 cycles
    for (int k = 0; k < 48; k++) begin
      chk($sformatf("b2b k%0d in_ready", k), in_ready, (k % 6) == 0);
      chk($sformatf("b2b k%0d out_valid", k), out_valid, (k % 6) == 5);
      if ((k % 6) == 5) begin
        vexp = (q.size() > 0) ? q.pop_front() : ~y;
        chk($sformatf("b2b k%0d y", k), y, vexp);
      end
      xr = {$urandom, $urandom, $urandom, $urandom};
      x = xr; in_valid = 1'b1; out_ready = 1'b1;
      if ((k % 6) == 0) q.push_back(model(xr, 1'b0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

`ifdef SWAN_VARTHETA_DIR_EN
    // Forward then inverse recovers the original input
    for (int i = 0; i < 1000; i++) begin
      xr = {$urandom, $urandom, $urandom, $urandom};
      do_op(xr, 1'b1, yv, lat);
      chk($sformatf("rt%0d fwd", i), yv, model(xr, 1'b1));
      do_op(yv, 1'b0, yv2, lat);
      chk($sformatf("rt%0d inv", i), yv2, xr);
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_inv_vartheta.md
SERIAL_INV_VARTHETA -- requirements
Module: serial_inv_vartheta

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 256, cipher block width in bits.
REQ-002 SHALL have parameter SIDE_SIZE, default BLOCK_SIZE/2, half-state width processed.
REQ-003 SHALL have parameter COLUMN_SIZE, default SIDE_SIZE/4, width of each of the 4 columns.
REQ-004 SHALL have parameters PA, PB, PC, defaults 1, 9, 19, rotation amounts of columns 2, 1 and 0.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, x is valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept x.
REQ-009 SHALL have port x, input, [0:SIDE_SIZE-1], input half-state; bit 0 is the MSB.
REQ-010 SHALL have port out_valid, output, 1, y is valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts y.
REQ-012 SHALL have port y, output, [0:SIDE_SIZE-1], result half-state; bit 0 is the MSB.

Function
REQ-013 SHALL split data into columns c[k] = bits [k*COLUMN_SIZE : (k+1)*COLUMN_SIZE-1], with k=0..3.
REQ-014 SHALL apply the inverse vartheta: c0 rotated left by PC, c1 rotated left by PB, c2 rotated left by PA, c3 unchanged; rotate left by P is {c[P:COLUMN_SIZE-1], c[0:P-1]}.
REQ-015 SHALL implement FSM states IDLE, ROT and DONE, with a 2-bit column counter col.
REQ-016 SHALL, in IDLE: drive in_ready=1; on in_valid&in_ready, capture x into the data register, set col=0 and go to ROT.
REQ-017 SHALL, in ROT: drive in_ready=0; each cycle rotate column col in place, then increment col; after col=3 is processed, go to DONE.
REQ-018 SHALL process column 3 with rotation 0, so ROT always lasts exactly 4 cycles.
REQ-019 SHALL, in DONE: drive out_valid=1, in_ready=0 and y=data register; on out_ready, go to IDLE with out_valid=0 the next cycle.
REQ-020 SHALL assert out_valid after the 5th rising edge counted from, and including, the accept edge (accept edge plus 4 ROT edges); y SHALL then stay stable until taken.
REQ-021 SHALL hold y stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 SHALL ignore in_valid outside IDLE; x changes during ROT or DONE SHALL have no effect.
REQ-023 SHALL keep out_valid=0 in IDLE and ROT, and SHALL ignore out_ready there.
REQ-024 SHALL never accept a new input and deliver an output in the same cycle; the minimum period is 6 cycles per block.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, set state=IDLE, col=0, data register=0, out_valid=0 and y=0.
REQ-026 SHALL hold in_ready=0 while rst=1, and drive in_ready=1 in the first cycle after rst deasserts.
REQ-027 SHALL, on reset asserted in ROT or DONE, abort the operation with no output produced.

Configuration
REQ-028 SHALL support macro SWAN_VARTHETA_DIR_EN.
REQ-029 SHALL, with SWAN_VARTHETA_DIR_EN defined, add input port dir (1 bit), sampled on the accept edge and held for the whole operation.
REQ-030 SHALL, with SWAN_VARTHETA_DIR_EN defined, rotate right (forward vartheta) when dir=1 and rotate left (inverse) when dir=0; the forward rotate right by P is {c[COLUMN_SIZE-P:COLUMN_SIZE-1], c[0:COLUMN_SIZE-1-P]}.
REQ-031 SHALL, with SWAN_VARTHETA_DIR_EN undefined, have no dir port and always perform the inverse; timing is identical in both builds.

Verification
REQ-032 SHALL cover basic inverse: x = 00000001_00000001_80000000_12345678 -> y = 00080000_00000200_00000001_12345678, out_valid rising after the 5th edge counted from, and including, the accept edge.
REQ-033 SHALL cover all-ones and all-zeros input: x = FFFF...F -> y = FFFF...F; x = 0 -> y = 0.
REQ-034 SHALL cover backpressure: hold out_ready=0 for 3 cycles in DONE -> y and out_valid stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset mid-operation: assert rst during the 2nd ROT cycle -> next cycle IDLE, out_valid=0, y=0, and no output for the aborted input.
REQ-036 SHALL cover the DIR_EN round trip: run random x with dir=1, then feed its y back with dir=0 -> output equals the original x, over 1000 vectors.
REQ-037 SHALL cover back-to-back operation: in_valid held high and out_ready held high -> one result every 6 cycles, each matching the reference model.
